reg_writeback_queue: RTL

//  Writer side of the 128-bit scalar register file write port (regWrEn / regToWrite / dataIn).

---
 rtl/reg_writeback_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Writer side of the scalar register file write port. Results from the
//   execute and memory producers are accepted over valid/ready handshakes,
//   buffered in order in a small FIFO, and retired at most one per cycle
//   into a registered write port. Also reports whether a register named by
//   either decoder read select still has a write queued or on the port.
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   The producer holds valid/reg/data stable until that edge. Ready depends
//   only on registered state (plus exValid for the memory side, since
//   execute has fixed priority).
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   exValid/exReady       execute handshake, exReg/exData payload
//   memValid/memReady     memory handshake, memReg/memData payload
//   wbStall               hold retirement this cycle
//   regWrEn/regToWrite/dataIn  registered register-file write port
//   rSel1/rSel2 -> busy1/busy2 pending-write status for the read selects
//   occupancy             current number of queued entries
module reg_writeback_queue #(
   parameter int regSize     = 128,
   parameter int regQuantity = 16,
   parameter int selBits     = 4,
   parameter int depth       = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         exValid,
   output logic                         exReady,
   input  logic [selBits-1:0]           exReg,
   input  logic [regSize-1:0]           exData,
   input  logic                         memValid,
   output logic                         memReady,
   input  logic [selBits-1:0]           memReg,
   input  logic [regSize-1:0]           memData,
   input  logic                         wbStall,
   output logic                         regWrEn,
   output logic [selBits-1:0]           regToWrite,
   output logic [regSize-1:0]           dataIn,
   input  logic [selBits-1:0]           rSel1,
   input  logic [selBits-1:0]           rSel2,
   output logic                         busy1,
   output logic                         busy2,
   output logic [$clog2(depth):0]       occupancy
);

   localparam int ptr_bits = $clog2(depth);
   localparam logic [ptr_bits:0] full_count = (ptr_bits + 1)'(depth);

   logic [selBits-1:0]  reg_mem  [depth];
   logic [regSize-1:0]  data_mem [depth];
   logic [ptr_bits-1:0] rd_ptr;
   logic [ptr_bits-1:0] wr_ptr;
   logic [ptr_bits:0]   count;

   logic                push;
   logic                pop;
   logic [selBits-1:0]  push_reg;
   logic [regSize-1:0]  push_data;

   assign exReady  = (count < full_count);
   assign memReady = (count < full_count) && !exValid;

   assign push      = (exValid && exReady) || (memValid && memReady);
   assign push_reg  = exValid ? exReg  : memReg;
   assign push_data = exValid ? exData : memData;

   // Pop decision uses the count before this edge's push, so an entry
   // pushed into an empty queue is never popped on the same edge.
   assign pop = (count != '0) && !wbStall;

   assign occupancy = count;

   // Storage needs no reset: only entries inside [rd_ptr, rd_ptr+count)
   // are ever observed.
   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem[wr_ptr]  <= push_reg;
         data_mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         regWrEn    <= 1'b0;
         regToWrite <= '0;
         dataIn     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            regWrEn    <= 1'b1;
            regToWrite <= reg_mem[rd_ptr];
            dataIn     <= data_mem[rd_ptr];
         end else begin
            regWrEn <= 1'b0;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // A register is busy if any live FIFO entry targets it, or if it is
   // being written on the port this cycle.
   logic [ptr_bits-1:0] scan_idx;

   always_comb begin
      busy1    = regWrEn && (regToWrite == rSel1);
      busy2    = regWrEn && (regToWrite == rSel2);
      scan_idx = '0;
      for (int i = 0; i < depth; i++) begin
         scan_idx = rd_ptr + ptr_bits'(i);
         if ((ptr_bits + 1)'(i) < count) begin
            if (reg_mem[scan_idx] == rSel1) busy1 = 1'b1;
            if (reg_mem[scan_idx] == rSel2) busy2 = 1'b1;
         end
      end
   end

endmodule
